// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between a requester and the apb_wait_slave completer.
interface apb_wait_slave_if #(
  parameter int unsigned ADDWIDTH  = 8,
  parameter int unsigned DATAWIDTH = 32
);
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDWIDTH-1:0]    PADDR;
  logic [DATAWIDTH-1:0]   PWDATA;
  logic [DATAWIDTH/8-1:0] PSTRB;
  logic                   PREADY;
  logic [DATAWIDTH-1:0]   PRDATA;
  logic                   PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_wait_slave.sv
// APB completer: byte-strobed register bank with programmable wait states and PSLVERR.
// Define APB_WAIT_SLAVE_ID_EN to make word 0 a read-only ID register returning SLV_ID.
module apb_wait_slave #(
  parameter int unsigned ADDWIDTH  = 8,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUMREGS   = 16,
  parameter logic [31:0] SLV_ID    = 32'hA5B0_0003
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic [3:0]    wait_cycles,
  apb_wait_slave_if.slave apb
);
  localparam int unsigned NumLanes = DATAWIDTH / 8;
  localparam int unsigned RegIdxW  = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;

  typedef enum logic {StIdle, StAccess} state_e;

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [RegIdxW-1:0]     idx_q;
  logic                   write_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [NumLanes-1:0]    strb_q;
  logic                   err_q;
  logic [DATAWIDTH-1:0]   regs_q [NUMREGS];

  logic [ADDWIDTH-3:0]    word_idx;
  logic                   setup_err;
  logic                   ready;
  logic [DATAWIDTH-1:0]   rdata;

  assign word_idx = apb.PADDR[ADDWIDTH-1:2];

  always_comb begin
    setup_err = (apb.PADDR[1:0] != 2'b00) || (32'(word_idx) >= NUMREGS);
`ifdef APB_WAIT_SLAVE_ID_EN
    if (apb.PWRITE && (word_idx == '0)) setup_err = 1'b1;
`endif
  end

  assign ready = (state_q == StAccess) && apb.PSEL && apb.PENABLE && (cnt_q == 4'd0);

  always_comb begin
    rdata = '0;
    if (ready && !write_q && !err_q) begin
`ifdef APB_WAIT_SLAVE_ID_EN
      if (idx_q == '0) rdata = DATAWIDTH'(SLV_ID);
      else             rdata = regs_q[idx_q];
`else
      rdata = regs_q[idx_q];
`endif
    end
  end

  assign apb.PREADY  = ready;
  assign apb.PRDATA  = rdata;
  assign apb.PSLVERR = ready && err_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUMREGS; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (apb.PSEL && !apb.PENABLE) begin
            idx_q   <= apb.PADDR[RegIdxW+1:2];
            write_q <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
            strb_q  <= apb.PSTRB;
            cnt_q   <= wait_cycles;
            err_q   <= setup_err;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // Dropping PSEL mid-transfer abandons it without touching the bank.
          if (!apb.PSEL) begin
            state_q <= StIdle;
          end else if (apb.PENABLE) begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q <= StIdle;
              if (write_q && !err_q) begin
                for (int unsigned b = 0; b < NumLanes; b++) begin
                  if (strb_q[b]) regs_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_wait_slave.sv
// Randomized bench for apb_wait_slave, checked every cycle against a transaction-level model.
module tb_apb_wait_slave;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam logic [31:0] ID = 32'hA5B0_0003;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [3:0] wait_cycles = 4'd0;

  apb_wait_slave_if #(.ADDWIDTH(AW), .DATAWIDTH(DW)) bus ();

  apb_wait_slave #(
    .ADDWIDTH (AW),
    .DATAWIDTH(DW),
    .NUMREGS  (NR),
    .SLV_ID   (ID)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .wait_cycles(wait_cycles),
    .apb        (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          check_en = 1'b0;
  logic        exp_ready;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] mem [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (check_en) begin
      check("PREADY", 32'(bus.PREADY), 32'(exp_ready));
      check("PSLVERR", 32'(bus.PSLVERR), 32'(exp_err));
      check("PRDATA", bus.PRDATA, exp_rdata);
    end
  end

  function automatic bit model_err(input bit wr, input logic [7:0] addr);
    bit e;
    e = (addr[1:0] != 2'b00) || ((addr >> 2) >= NR);
`ifdef APB_WAIT_SLAVE_ID_EN
    if (wr && (addr >> 2) == 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] addr);
`ifdef APB_WAIT_SLAVE_ID_EN
    if ((addr >> 2) == 0) return ID;
`endif
    return mem[addr >> 2];
  endfunction

  task automatic clear_exp();
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic idle(input int n);
    clear_exp();
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  // Starts at posedge+1; returns at posedge+1 with the bus idle. abort_k >= 0 aborts at that
  // access cycle either by reset (abort_rst) or by dropping PSEL.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int w, input int abort_k, input bit abort_rst,
                      output logic [31:0] got_rdata, output logic got_err, output int lat);
    bit err;
    err = model_err(wr, addr);
    got_rdata = '0;
    got_err = 1'b0;
    lat = -1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
    bus.PWDATA = data; bus.PSTRB = strb; wait_cycles = 4'(w);
    clear_exp();
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    wait_cycles = 4'($urandom_range(0, 15));
    for (int k = 0; k <= w; k++) begin
      if (k == abort_k) begin
        clear_exp();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        if (abort_rst) PRESETn = 1'b0;
        @(posedge PCLK); #1;
        if (abort_rst) begin
          @(posedge PCLK); #1;
          PRESETn = 1'b1;
          for (int i = 0; i < NR; i++) mem[i] = '0;
        end
        return;
      end
      exp_ready = (k == w);
      exp_err   = exp_ready && err;
      exp_rdata = (exp_ready && !wr && !err) ? model_read(addr) : 32'h0;
      @(negedge PCLK);
      if (bus.PREADY === 1'b1 && lat < 0) begin
        lat = k + 1;
        got_rdata = bus.PRDATA;
        got_err = bus.PSLVERR;
      end
      @(posedge PCLK); #1;
    end
    if (wr && !err) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mem[addr >> 2][8*b +: 8] = data[8*b +: 8];
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    clear_exp();
  endtask

  logic [31:0] r;
  logic        e;
  int          l;

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    clear_exp();
    for (int i = 0; i < NR; i++) mem[i] = '0;
    @(posedge PCLK); #1;
    check_en = 1'b1;
    repeat (2) begin
      @(posedge PCLK); #1;
    end
    PRESETn = 1'b1;
    idle(5);

    // Zero-wait write then read.
    xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, -1, 1'b0, r, e, l);
    check("wr04_lat", 32'(l), 32'd1);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd04_data", r, 32'hDEADBEEF);
    check("rd04_lat", 32'(l), 32'd1);
    idle(1);

    // Three wait states.
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 3, -1, 1'b0, r, e, l);
    check("rd04_w3_lat", 32'(l), 32'd4);
    check("rd04_w3_data", r, 32'hDEADBEEF);

    // Back-to-back strobed writes.
    xfer(1'b1, 8'h08, 32'h11223344, 4'hF, 1, -1, 1'b0, r, e, l);
    xfer(1'b1, 8'h08, 32'hAABBCCDD, 4'b0101, 2, -1, 1'b0, r, e, l);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd08_strb", r, 32'h11BB33DD);

    // Decode errors.
    xfer(1'b0, 8'h02, 32'h0, 4'h0, 1, -1, 1'b0, r, e, l);
    check("rd02_err", 32'(e), 32'd1);
    check("rd02_data", r, 32'h0);
    xfer(1'b0, 8'h40, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd40_err", 32'(e), 32'd1);
    xfer(1'b1, 8'h02, 32'hFFFFFFFF, 4'hF, 0, -1, 1'b0, r, e, l);
    check("wr02_err", 32'(e), 32'd1);
    xfer(1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 2, -1, 1'b0, r, e, l);
    check("wr40_err", 32'(e), 32'd1);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
`ifdef APB_WAIT_SLAVE_ID_EN
    check("rd00_after_err", r, ID);
`else
    check("rd00_after_err", r, 32'h0);
`endif

    // PSEL with PENABLE but no setup phase: must be ignored.
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
    bus.PADDR = 8'h04; bus.PWDATA = 32'h0; bus.PSTRB = 4'hF;
    idle(3);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    idle(1);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd04_no_setup", r, 32'hDEADBEEF);

    // Reset during the third wait cycle of a write.
    xfer(1'b1, 8'h0C, 32'h5, 4'hF, 5, 2, 1'b1, r, e, l);
    xfer(1'b0, 8'h0C, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd0C_after_rst", r, 32'h0);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 1, -1, 1'b0, r, e, l);
    check("rd04_after_rst", r, 32'h0);

`ifdef APB_WAIT_SLAVE_ID_EN
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd00_id", r, ID);
    xfer(1'b1, 8'h00, 32'h12345678, 4'hF, 1, -1, 1'b0, r, e, l);
    check("wr00_err", 32'(e), 32'd1);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd00_id_kept", r, ID);
`else
    xfer(1'b1, 8'h00, 32'h12345678, 4'hF, 1, -1, 1'b0, r, e, l);
    check("wr00_err", 32'(e), 32'd0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 0, -1, 1'b0, r, e, l);
    check("rd00_rw", r, 32'h12345678);
`endif

    // Randomized traffic with gaps, aborts and assorted wait states.
    repeat (300) begin
      bit          wr;
      logic [7:0]  addr;
      int          w;
      int          ak;
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 99) < 85) ? 8'($urandom_range(0, 15) * 4) : 8'($urandom);
      w    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      ak   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, w)) : -1;
      xfer(wr, addr, $urandom, 4'($urandom), w, ak, 1'b0, r, e, l);
      if (ak < 0) check("rand_lat", 32'(l), 32'(w + 1));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
